// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU types: the 3-bit operation code produced by the ALU control
// decoder and the state encoding of the multi-cycle ALU.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } alu_state_t;

    // True for the two ops that go through the serial shifter.
    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// -----------------------------------------------------------------------------
// alu_serial_shifter
// Zero-fill logical shifter that moves its operand one bit per clock.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_load         capture i_data / i_dir / i_amount and start shifting
//   i_dir          0 = shift left, 1 = shift right
//   i_amount       number of 1-bit steps to perform
//   i_data         value to shift
//   o_data_next    value after the step taken in the current cycle
//   o_done         the current cycle performs the final step
// -----------------------------------------------------------------------------
module alu_serial_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_dir,
    input  logic [SHW-1:0]   i_amount,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data_next,
    output logic             o_done
);

    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};

    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_count;
    logic             r_dir;
    logic [WIDTH-1:0] w_shifted;

    // One-bit zero-fill step in the captured direction.
    always_comb begin
        w_shifted = {WIDTH{1'b0}};
        if (r_dir) begin
            w_shifted = {1'b0, r_data[WIDTH-1:1]};
        end else begin
            w_shifted = {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign o_data_next = w_shifted;
    // Signalled while the last step is being taken so the owner can capture
    // o_data_next at the same edge the count reaches zero.
    assign o_done      = (r_count == CNT_ONE);

    // Operand/count registers: load, then step until the count is exhausted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= {WIDTH{1'b0}};
            r_count <= CNT_ZERO;
            r_dir   <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_count <= i_amount;
            r_dir   <= i_dir;
        end else if (r_count != CNT_ZERO) begin
            r_data  <= w_shifted;
            r_count <= r_count - CNT_ONE;
        end else begin
            r_data  <= r_data;
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// Multi-cycle MIPS ALU. add/sub/and/or/nor/slt complete with latency 1;
// sll/srl use a serial shifter (one bit per cycle). Requests and results move
// over valid/ready handshakes; a result is held until accepted.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   alucontrol, a, b      operation code and operands (b is the shifted value)
//   shamt                 shift amount, ignored for non-shift ops
//   out_valid / out_ready result handshake
//   result, zero          registered result and its zero flag
//   busy                  an operation is in flight or waiting to retire
//   ovf                   signed add/sub overflow (only with ALU_OVF_EN)
// Configuration macro: ALU_OVF_EN adds the ovf port and its logic.
// -----------------------------------------------------------------------------
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    alu_state_t       r_state;
    alu_state_t       w_next_state;
    logic [WIDTH-1:0] r_result;
    alu_op_t          w_op;
    logic             w_accept;
    logic             w_shift_load;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_result;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_shift_done;

    assign w_op         = alu_op_t'(alucontrol);
    assign w_accept     = in_valid && (r_state == IDLE);
    // A zero-amount shift is a plain move of b and retires like a 1-cycle op.
    assign w_shift_load = w_accept && is_shift(w_op) && (shamt != {SHW{1'b0}});
    assign w_sum        = a + b;
    assign w_diff       = a - b;

    // Single-cycle datapath evaluated on the accept cycle.
    always_comb begin
        w_alu_result = {WIDTH{1'b0}};
        case (w_op)
            ALU_ADD: w_alu_result = w_sum;
            ALU_SUB: w_alu_result = w_diff;
            ALU_AND: w_alu_result = a & b;
            ALU_OR:  w_alu_result = a | b;
            ALU_NOR: w_alu_result = ~(a | b);
            ALU_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: w_alu_result = b;
            ALU_SRL: w_alu_result = b;
            default: w_alu_result = {WIDTH{1'b0}};
        endcase
    end

    alu_serial_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_shift_load),
        .i_dir       (w_op == ALU_SRL),
        .i_amount    (shamt),
        .i_data      (b),
        .o_data_next (w_shift_next),
        .o_done      (w_shift_done)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic. Single-cycle ops finish within the accept cycle,
    // so EXEC is never entered; it only falls through to DONE if reached.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_shift_load) begin
                        w_next_state = SHIFT;
                    end else begin
                        w_next_state = DONE;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXEC: w_next_state = DONE;
            SHIFT: begin
                if (w_shift_done) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Result register: loaded on accept or on the final shift step, else held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_result <= w_alu_result;
        end else if ((r_state == SHIFT) && w_shift_done) begin
            r_result <= w_shift_next;
        end else begin
            r_result <= r_result;
        end
    end

`ifdef ALU_OVF_EN
    logic r_ovf;
    logic w_alu_ovf;

    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // result sign differs from a.
    always_comb begin
        w_alu_ovf = 1'b0;
        case (w_op)
            ALU_ADD: w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            ALU_SUB: w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            default: w_alu_ovf = 1'b0;
        endcase
    end

    // Overflow flag registered alongside the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_alu_ovf;
        end else if ((r_state == SHIFT) && w_shift_done) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    // Outputs are decodes of registered state/result only.
    assign result    = r_result;
    assign zero      = (r_result == {WIDTH{1'b0}});
    assign out_valid = (r_state == DONE);
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
// Directed test of alu_multicycle with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif

    int n_checks;
    int n_errors;

    alu_multicycle #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .busy       (busy)
`ifdef ALU_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling/driving happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle T) and leave the bench in T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [4:0] sh);
        check("in_ready_before_issue", in_ready, 1'b1);
        in_valid   = 1'b1;
        alucontrol = op;
        a          = va;
        b          = vb;
        shamt      = sh;
        tick();
        in_valid   = 1'b0;
        alucontrol = 3'd0;
        a          = 32'h1234_5678;
        b          = 32'h0BAD_F00D;
        shamt      = 5'd3;
    endtask

    // Wait (bounded) for out_valid and check the latency counted from T.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        int ir_bad;
        lat    = 1;
        ir_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_bad++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_in_ready_low"}, ir_bad, 0);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_out_valid", out_valid, 1'b0);
        check("retire_in_ready", in_ready, 1'b1);
    endtask

    // Single-cycle op: issue, expect latency 1, check result and zero, retire.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_res, input logic exp_ovf);
        issue(op, va, vb, 5'd0);
        wait_result(tag, 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, zero, (exp_res == 32'd0));
`ifdef ALU_OVF_EN
        check({tag, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf !== 1'bx) begin
        end
`endif
        retire();
    endtask

    initial begin
        int stray;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        alucontrol = 3'd0;
        a          = 32'd0;
        b          = 32'd0;
        shamt      = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_zero", zero, 1'b1);

        // Arithmetic/logic, including wrap and overflow boundaries.
        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
        run_op("sub_eq",  3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
        run_op("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
        run_op("slt_pos", 3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("and",     3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        run_op("or",      3'd3, 32'hF0F0_0000, 32'h0000_1234, 32'hF0F0_1234, 1'b0);
        run_op("add_wrap",3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        run_op("sub_ovf", 3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);

        // Serial shifts.
        issue(3'd6, 32'h0, 32'h0000_0001, 5'd31);
        wait_result("sll31", 32);
        check("sll31_result", result, 32'h8000_0000);
        retire();

        issue(3'd7, 32'h0, 32'hDEAD_BEEF, 5'd0);
        wait_result("srl0", 1);
        check("srl0_result", result, 32'hDEAD_BEEF);
        retire();

        issue(3'd7, 32'h0, 32'hDEAD_BEEF, 5'd4);
        wait_result("srl4", 5);
        check("srl4_result", result, 32'h0DEA_DBEE);
        retire();

        issue(3'd6, 32'h0, 32'h8000_0001, 5'd1);
        wait_result("sll1", 2);
        check("sll1_result", result, 32'h0000_0002);
        retire();

        // Back-pressure: result held, new request ignored while waiting.
        issue(3'd4, 32'h0, 32'h0, 5'd0);
        in_valid   = 1'b1;
        alucontrol = 3'd0;
        a          = 32'd1;
        b          = 32'd1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_result", result, 32'hFFFF_FFFF);
            tick();
        end
        in_valid = 1'b0;
        check("bp_still_valid", out_valid, 1'b1);
        check("bp_still_result", result, 32'hFFFF_FFFF);
        retire();
        tick();
        check("bp_no_extra_op", out_valid, 1'b0);

        // Reset in the middle of a 20-step shift (cycle T+7).
        issue(3'd7, 32'h0, 32'hFFFF_FFFF, 5'd20);
        for (int i = 0; i < 6; i++) tick();
        check("mid_busy", busy, 1'b1);
        reset      = 1'b1;
        in_valid   = 1'b1;
        alucontrol = 3'd0;
        a          = 32'd7;
        b          = 32'd9;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_result", result, 32'd0);
        check("mrst_zero", zero, 1'b1);
        check("mrst_in_ready", in_ready, 1'b1);
        check("mrst_busy", busy, 1'b0);
`ifdef ALU_OVF_EN
        check("mrst_ovf", ovf, 1'b0);
`endif
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid || busy) stray++;
            tick();
        end
        check("mrst_no_stray", stray, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
